ser_frame_receiver: RTL and testbench

SER_FRAME_RECEIVER -- requirements
Module: ser_frame_receiver

---
 rtl/sap3_ser_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/ser_frame_receiver.sv | 126 ++++++++++++
 tb/tb_ser_frame_receiver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sap3_ser_pkg.sv
// Shared constants and types for the SAP-3 serial link (serializer and receiver).
package sap3_ser_pkg;

  // Serializer side: frame geometry and bit order.
  localparam int SER_WIDTH     = 8;
  localparam int SER_LSB_FIRST = 1;

  // Receiver side: default receive FIFO depth (power of two, >= 2).
  localparam int SER_DEPTH     = 4;

  // Receiver frame-assembly states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head entry is held in a register so the
// output is defined after reset and keeps its last value while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [PTR_W:0]   level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == (PTR_W+1)'(DEPTH));
  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees the slot in the same cycle.
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
  assign data_o     = head_q;
  assign level_o    = level_q;

  // Next occupancy and next head value.
  always_comb begin
    level_d = level_q;
    head_d  = head_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
    if (do_pop) begin
      if (level_q > (PTR_W+1)'(1)) head_d = mem_q[rd_ptr_nxt];
      else if (do_push)            head_d = data_i;
    end else if (empty_o && do_push) begin
      head_d = data_i;
    end
  end

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers (wrap naturally at DEPTH), occupancy and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/ser_frame_receiver.sv
// Serial frame receiver: assembles LSB-first frames marked by a start strobe,
// queues completed bytes in a FWFT FIFO and tracks aborts and drops.
module ser_frame_receiver
  import sap3_ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int DEPTH = SER_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   serial_in,
  input  logic                   start_in,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   err_clr,
  output logic                   overrun,
  output logic [7:0]             abort_cnt,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             push, abort, drop, pop, fifo_full, fifo_empty;
  logic             overrun_q;
  logic [7:0]       abort_cnt_q, drop_cnt_q;

  // Frame assembly: next state, bit counter, shift register, push/abort strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          shift_d    = '0;
          shift_d[0] = serial_in;
          cnt_d      = CNT_W'(1);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start_in) begin
          // New start mid-frame: drop the partial byte and restart.
          abort      = 1'b1;
          shift_d    = '0;
          shift_d[0] = serial_in;
          cnt_d      = CNT_W'(1);
        end else begin
          shift_d[cnt_q] = serial_in;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame-assembly registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // The pushed byte includes the bit captured on this edge, hence shift_d.
  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (shift_d),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = push & fifo_full & ~pop;

  // Sticky error flag and saturating counters; clear wins over events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      abort_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else if (err_clr) begin
      overrun_q   <= 1'b0;
      abort_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (drop) begin
        overrun_q  <= 1'b1;
        drop_cnt_q <= sat_inc8(drop_cnt_q);
      end
      if (abort) abort_cnt_q <= sat_inc8(abort_cnt_q);
    end
  end

  assign overrun   = overrun_q;
  assign abort_cnt = abort_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ser_frame_receiver.sv
// Bench for ser_frame_receiver: directed scenarios plus random frames,
// checked every cycle against a byte-queue model of the receiver.
module tb_ser_frame_receiver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   serial_in, start_in, out_ready, err_clr;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid, overrun;
  logic [7:0]             abort_cnt, drop_cnt;
  logic [$clog2(DEPTH):0] level;

  ser_frame_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .serial_in (serial_in),
    .start_in  (start_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .overrun   (overrun),
    .abort_cnt (abort_cnt),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of bytes waiting for the consumer plus error state.
  logic [7:0] mq[$];
  logic       m_ovr;
  logic [7:0] m_abort, m_drop, m_hold;
  bit         frame_open;
  logic [7:0] rx_log[$];  // bytes actually handed over by the DUT

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0; m_abort = '0; m_drop = '0; m_hold = '0;
    frame_open = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("level", level, mq.size());
    check_eq("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("out_data", out_data, mq[0]);
      m_hold = mq[0];
    end else begin
      check_eq("out_data_hold", out_data, m_hold);
    end
    check_eq("overrun", overrun, m_ovr);
    check_eq("abort_cnt", abort_cnt, m_abort);
    check_eq("drop_cnt", drop_cnt, m_drop);
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  // done/db: this cycle carries the last bit of byte db; ab: this start aborts a frame.
  task automatic step(input logic ser, input logic st, input logic rdy, input logic clr,
                      input logic done, input logic [7:0] db, input logic ab);
    serial_in = ser; start_in = st; out_ready = rdy; err_clr = clr;
    if (out_valid && rdy) rx_log.push_back(out_data);
    @(posedge clk);
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < DEPTH) mq.push_back(db);
      else begin
        m_ovr  = 1'b1;
        m_drop = sat8(m_drop);
      end
    end
    if (ab) m_abort = sat8(m_abort);
    if (clr) begin
      m_ovr = 1'b0; m_abort = '0; m_drop = '0;
    end
    #1;
    compare_all();
  endtask

  // rdy_mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the last bit.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int rdy_mode);
    for (int i = 0; i < nbits; i++) begin
      logic rdy, last;
      last = (nbits == WIDTH) && (i == WIDTH-1);
      case (rdy_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = last;
      endcase
      step(b[i], i == 0, rdy, 1'b0, last, b, (i == 0) && frame_open);
      if (i == 0) frame_open = 1'b1;
      if (last)   frame_open = 1'b0;
    end
  endtask

  task automatic idle(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++) begin
      logic rdy;
      rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'($urandom_range(0, 1)), 1'b0, rdy, 1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int rdy_mode, input int gap);
    $display("FRAME data=%02h rdy_mode=%0d gap=%0d level=%0d", b, rdy_mode, gap, level);
    send_bits(b, WIDTH, rdy_mode);
    idle(gap, rdy_mode);
  endtask

  task automatic clear_errors();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; serial_in = 1'b0; start_in = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    #12;
    compare_all();
    check_eq("rst_data", out_data, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Single frame 0xA5, consumer always ready.
    send_frame(8'hA5, 1, 0);
    check_eq("a5_valid", out_valid, 1'b1);
    check_eq("a5_data", out_data, 8'hA5);
    idle(1, 1);
    check_eq("a5_gone", out_valid, 1'b0);
    check_eq("a5_rx", rx_log[$], 8'hA5);

    // Five back-to-back frames into a stalled consumer: one drop.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 0, 0);
    check_eq("b2b_level", level, 4);
    check_eq("b2b_drop", drop_cnt, 1);
    check_eq("b2b_ovr", overrun, 1'b1);
    idle(5, 1);
    for (int j = 0; j < 4; j++) check_eq("b2b_order", rx_log[rx_log.size()-4+j], j + 1);
    clear_errors();

    // Restart at bit 3, then full frame 0x3C.
    n0 = rx_log.size();
    send_bits(8'hFF, 3, 1);
    send_frame(8'h3C, 1, 2);
    check_eq("abort_cnt1", abort_cnt, 1);
    check_eq("abort_nrx", rx_log.size() - n0, 1);
    check_eq("abort_rx", rx_log[$], 8'h3C);

    // Full FIFO, 0x77 completes together with a pop.
    clear_errors();
    for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 0, 0);
    send_frame(8'h77, 3, 0);
    check_eq("fullpop_level", level, 4);
    check_eq("fullpop_drop", drop_cnt, 0);
    idle(6, 1);
    check_eq("fullpop_last", rx_log[$], 8'h77);
    check_eq("fullpop_prev", rx_log[rx_log.size()-2], 8'h14);

    // Reset pulsed mid-frame (after bit 4), then frame 0x5A.
    send_bits(8'hC3, 5, 1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_level", level, 0);
    check_eq("mrst_data", out_data, 8'h00);
    check_eq("mrst_abort", abort_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    n0 = rx_log.size();
    send_frame(8'h5A, 1, 2);
    check_eq("mrst_nrx", rx_log.size() - n0, 1);
    check_eq("mrst_rx", rx_log[$], 8'h5A);

    // Drop-counter saturation, then clear.
    for (int k = 0; k < 304; k++) send_frame(8'(k), 0, 0);
    check_eq("sat_drop", drop_cnt, 255);
    check_eq("sat_ovr", overrun, 1'b1);
    clear_errors();
    check_eq("clr_drop", drop_cnt, 0);
    check_eq("clr_ovr", overrun, 1'b0);
    idle(6, 1);

    // Random traffic with occasional aborts and clears.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 7) == 0) send_bits(8'($urandom), $urandom_range(1, 7), 2);
      send_frame(8'($urandom), 2, $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) clear_errors();
    end
    idle(8, 1);
    check_eq("end_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
